sp_ram_stream_reader: RTL and testbench

- Read sequencer that sits directly upstream of the single-port RAM.
- On a start command it issues a burst of LEN consecutive reads from BASE, wrapping at MEM_DEPTH-1.
- It accounts for the RAM's one-cycle registered read latency and presents the words on a valid/ready stream with a last flag.
- A 2-entry output buffer gives full throughput under backpressure without re-reading the RAM.

---
 rtl/sp_ram_pkg.sv | 19 +
 rtl/sp_ram_stream_reader_if.sv | 28 ++
 rtl/sp_stream_fifo2.sv | 65 ++++++
 rtl/sp_ram_stream_reader.sv | 132 +++++++++++++
 tb/tb_sp_ram_stream_reader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types for the single-port RAM stream reader: FSM states and output buffer entry.
package sp_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned FIFO_DEPTH       = 2;
  localparam int unsigned ENTRY_DATA_WIDTH = 16;

  typedef struct packed {
    logic [ENTRY_DATA_WIDTH-1:0] data;
    logic                        last;
  } entry_t;

endpackage

// File: rtl/sp_ram_stream_reader_if.sv
// RAM read port plus output stream of the reader; master is the reader side.
interface sp_ram_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  ram_en;
  logic                  ram_wr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output ram_en, ram_wr, ram_addr,
    input  ram_rdata,
    output out_data, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  ram_en, ram_wr, ram_addr,
    output ram_rdata,
    input  out_data, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/sp_stream_fifo2.sv
// Two-entry valid/ready buffer; an incoming word falls straight through to the head when empty.
module sp_stream_fifo2
  import sp_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  entry_t     push_entry,
  output logic       pop_valid,
  input  logic       pop_ready,
  output entry_t     pop_entry,
  output logic [1:0] occupancy
);

  entry_t     mem [FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       pop;
  logic       store;
  logic       unload;

  always_comb begin
    pop_valid = (count != 2'd0) || push_valid;
    pop_entry = '0;
    if (count != 2'd0) begin
      pop_entry = mem[rd_ptr];
    end else if (push_valid) begin
      pop_entry = push_entry;
    end
    pop    = pop_valid && pop_ready;
    // a word consumed in its arrival cycle never touches storage
    store  = push_valid && !((count == 2'd0) && pop);
    unload = pop && (count != 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (store) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (unload) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({store, unload})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign occupancy = count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(store && !unload && (count == 2'(FIFO_DEPTH))));

endmodule

// File: rtl/sp_ram_stream_reader.sv
// Burst read sequencer for a single-port RAM with one-cycle read latency, streaming words out.
//   state | meaning
//   IDLE  | waiting for start, burst parameters latched on accept
//   RUN   | issuing reads while buffer + in-flight has room
//   DRAIN | all reads issued, waiting for the last word to be accepted
//   DONE  | one-cycle completion pulse
module sp_ram_stream_reader
  import sp_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  sp_ram_stream_reader_if.master bus
);

  state_e                state;
  state_e                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  iss_cnt;
  logic [LEN_WIDTH-1:0]  acc_cnt;
  logic                  inflight;
  logic                  inflight_last;
  logic                  issue;
  logic                  final_issue;
  logic                  final_accept;
  logic                  pop;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] rd_word;
  entry_t                push_entry;
  entry_t                head;
  logic                  head_valid;

  assign rd_word      = bus.ram_rdata;
  assign final_issue  = (iss_cnt == len_q - LEN_WIDTH'(1));
  assign final_accept = (acc_cnt == len_q - LEN_WIDTH'(1));
  assign pop          = head_valid && bus.out_ready;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        issue = ((occ + {1'b0, inflight}) < 2'd2);
        if (issue && final_issue) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // the final read is always in flight or buffered here, so its accept ends the burst
        if (pop && final_accept) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      iss_cnt       <= '0;
      acc_cnt       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      inflight      <= issue;
      inflight_last <= issue && final_issue;
      if ((state == IDLE) && start) begin
        addr_q  <= base_addr;
        len_q   <= burst_len;
        iss_cnt <= '0;
        acc_cnt <= '0;
      end
      if (issue) begin
        addr_q  <= (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
        iss_cnt <= iss_cnt + LEN_WIDTH'(1);
      end
      if (pop) begin
        acc_cnt <= acc_cnt + LEN_WIDTH'(1);
      end
    end
  end

  // RAM output is held while idle, so the registered in-flight flag alone qualifies capture
  assign push_entry.data = rd_word;
  assign push_entry.last = inflight_last;

  sp_stream_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (inflight),
    .push_entry (push_entry),
    .pop_valid  (head_valid),
    .pop_ready  (bus.out_ready),
    .pop_entry  (head),
    .occupancy  (occ)
  );

  assign bus.ram_en    = issue;
  assign bus.ram_wr    = 1'b0;
  assign bus.ram_addr  = addr_q;
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head.data;
  assign bus.out_last  = head.last;

endmodule

// File: tb/tb_sp_ram_stream_reader.sv
// Scoreboard bench for sp_ram_stream_reader: directed bursts against a registered-read RAM model.
module tb_sp_ram_stream_reader;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int LW = 4;
  localparam int MD = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] burst_len = '0;
  logic          busy;
  logic          done;

  sp_ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sp_ram_stream_reader #(
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (MD),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [MD];
  initial begin
    for (int i = 0; i < MD; i++) ram[i] = {4'(i + 4), 4'(i + 3), 4'(i + 2), 4'(i + 1)};
  end

  always @(posedge clk) begin
    if (bus.ram_en && !bus.ram_wr) bus.ram_rdata <= ram[bus.ram_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  exp_t          e;
  logic [AW-1:0] ea;

  int issued = 0, accepted = 0, done_cnt = 0;
  int first_valid_cyc = -1, done_cyc = -1, last_acc_cyc = -1;
  int start_cyc = 0, done_base = 0;
  logic          stalled = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ram_en) begin
        check("issue_room", ((issued - accepted) < 2) ? 32'd1 : 32'd0, 32'd1);
        check("ram_wr_low", bus.ram_wr, 0);
        check("issue_expected", (addr_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (addr_q.size() != 0) begin
          ea = addr_q.pop_front();
          check("ram_addr", bus.ram_addr, ea);
        end
        issued++;
      end
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stalled) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, stall_data);
        check("stall_last", bus.out_last, stall_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("word_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_last", bus.out_last, e.last);
        end
        accepted++;
        last_acc_cyc = cyc;
      end
      stalled    = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      stall_last = bus.out_last;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    exp_t x;
    x.data = d;
    x.last = l;
    exp_q.push_back(x);
    addr_q.push_back(a);
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    tick();
    start           = 1'b1;
    base_addr       = b;
    burst_len       = l;
    start_cyc       = cyc;
    first_valid_cyc = -1;
    done_cyc        = -1;
    done_base       = done_cnt;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating
  task automatic wait_done(input int mode, input int max_cycles);
    for (int k = 0; k < max_cycles && done_cnt == done_base; k++) begin
      if (mode == 1) bus.out_ready = (((cyc - start_cyc) % 4) == 0) || (((cyc - start_cyc) % 4) == 3);
      else           bus.out_ready = 1'b1;
      tick();
    end
    check("done_seen", (done_cnt != done_base) ? 32'd1 : 32'd0, 32'd1);
    bus.out_ready = 1'b1;
  endtask

  task automatic check_drained(input string name);
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_addr_left"}, addr_q.size(), 0);
  endtask

  int n0, d0, a0;

  initial begin
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ram_en", bus.ram_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", bus.out_data, 0);
    rst = 1'b1;
    tick();

    // 1: base 0, len 3, ready high
    expect_word(3'd0, 16'h4321, 1'b0);
    expect_word(3'd1, 16'h5432, 1'b0);
    expect_word(3'd2, 16'h6543, 1'b1);
    pulse_start(3'd0, 4'd3);
    check("t1_busy", busy, 1);
    wait_done(0, 40);
    check("t1_first_valid_lat", first_valid_cyc - start_cyc, 2);
    check("t1_done_lat", done_cyc - start_cyc, 5);
    check("t1_done_after_accept", done_cyc - last_acc_cyc, 1);
    check("t1_done_width", done, 0);
    check("t1_busy_after", busy, 0);
    check_drained("t1");

    // 2: wrap from address 7 to 0
    expect_word(3'd6, 16'hA987, 1'b0);
    expect_word(3'd7, 16'hBA98, 1'b0);
    expect_word(3'd0, 16'h4321, 1'b0);
    expect_word(3'd1, 16'h5432, 1'b1);
    pulse_start(3'd6, 4'd4);
    wait_done(0, 40);
    check("t2_first_valid_lat", first_valid_cyc - start_cyc, 2);
    check("t2_done_after_accept", done_cyc - last_acc_cyc, 1);
    check_drained("t2");

    // 3: backpressure
    expect_word(3'd0, 16'h4321, 1'b0);
    expect_word(3'd1, 16'h5432, 1'b0);
    expect_word(3'd2, 16'h6543, 1'b0);
    expect_word(3'd3, 16'h7654, 1'b1);
    pulse_start(3'd0, 4'd4);
    wait_done(1, 60);
    check("t3_done_after_accept", done_cyc - last_acc_cyc, 1);
    check_drained("t3");

    // 4: zero length
    n0 = issued;
    pulse_start(3'd5, 4'd0);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    tick();
    check("t4_done_width", done, 0);
    check("t4_no_issue", issued - n0, 0);
    check("t4_no_valid", (first_valid_cyc < 0) ? 32'd1 : 32'd0, 32'd1);

    // 5: start during RUN is ignored
    expect_word(3'd2, 16'h6543, 1'b0);
    expect_word(3'd3, 16'h7654, 1'b0);
    expect_word(3'd4, 16'h8765, 1'b1);
    pulse_start(3'd2, 4'd3);
    start     = 1'b1;
    base_addr = 3'd3;
    burst_len = 4'd5;
    tick();
    start = 1'b0;
    wait_done(0, 40);
    n0 = issued;
    repeat (6) tick();
    check("t5_busy_after", busy, 0);
    check("t5_no_reissue", issued - n0, 0);
    check("t5_single_done", done_cnt - done_base, 1);
    check_drained("t5");

    // 6: reset after two of five words
    for (int i = 0; i < 5; i++) expect_word(3'(i), ram[i], (i == 4));
    a0 = accepted;
    pulse_start(3'd0, 4'd5);
    for (int k = 0; k < 20 && (accepted - a0) < 2; k++) tick();
    check("t6_two_delivered", accepted - a0, 2);
    d0 = done_cnt;
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_ram_en", bus.ram_en, 0);
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_out_data", bus.out_data, 0);
    check("t6_rst_out_last", bus.out_last, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_ram_addr", bus.ram_addr, 0);
    exp_q.delete();
    addr_q.delete();
    issued = accepted;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("t6_no_done", done_cnt - d0, 0);
    expect_word(3'd1, 16'h5432, 1'b1);
    pulse_start(3'd1, 4'd1);
    wait_done(0, 20);
    check("t6_first_valid_lat", first_valid_cyc - start_cyc, 2);
    check("t6_done_after_accept", done_cyc - last_acc_cyc, 1);
    check_drained("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
